periph_bus_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit peripheral register bus (`peripheral_addr_in`/`peripheral_data_in`/`peripheral_read_en`/`peripheral_write_en` in, `peripheral_data_out`/`peripheral_data_out_en` back).
- Grants the bus round-robin to one requester at a time.
- Issues a single-cycle read or write strobe.
- Waits for the slave's registered read response.
- Terminates unanswered reads (unmapped addresses return no `peripheral_data_out_en`) with a timeout error.
- Sits between the host command path / status poller and all uartctrl-style register slaves in the `clk_125` domain.

---
 rtl/periph_bus_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin two-requester arbiter/sequencer for the 32-bit
// peripheral register bus, with read-response timeout and error reporting.
`default_nettype none

module periph_bus_arbiter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk_125,
  input  logic        rst_n_125,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_read_en,
  output logic        bus_write_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdata_en,
  output logic [15:0] timeout_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic        last_grant_q;
  logic        gnt_q;
  logic        wr_q;
  logic [7:0]  wait_cnt_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic        bus_read_en_q;
  logic        bus_write_en_q;
  logic        m0_ack_q;
  logic [31:0] m0_rdata_q;
  logic        m0_err_q;
  logic        m1_ack_q;
  logic [31:0] m1_rdata_q;
  logic        m1_err_q;
  logic [15:0] timeout_cnt_q;

  logic        gnt_d;
  logic        fin_d;
  logic [31:0] fin_rdata_d;
  logic        fin_err_d;

  // On a tie the requester not granted last time wins; a lone request wins outright.
  assign gnt_d = (m0_req && m1_req) ? ~last_grant_q : m1_req;

  always_comb begin
    fin_d       = 1'b0;
    fin_rdata_d = 32'h0;
    fin_err_d   = 1'b0;
    case (state_q)
      S_ISSUE: fin_d = wr_q;
      S_WAIT_RD: begin
        if (bus_rdata_en) begin
          fin_d       = 1'b1;
          fin_rdata_d = bus_rdata;
        end else if (wait_cnt_q == TO_LAST) begin
          fin_d     = 1'b1;
          fin_err_d = 1'b1;
        end
      end
      default: fin_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 1'b1;
      gnt_q          <= 1'b0;
      wr_q           <= 1'b0;
      wait_cnt_q     <= 8'd0;
      bus_addr_q     <= 32'h0;
      bus_wdata_q    <= 32'h0;
      bus_read_en_q  <= 1'b0;
      bus_write_en_q <= 1'b0;
      m0_ack_q       <= 1'b0;
      m0_rdata_q     <= 32'h0;
      m0_err_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m1_rdata_q     <= 32'h0;
      m1_err_q       <= 1'b0;
      timeout_cnt_q  <= 16'h0;
    end else begin
      bus_read_en_q  <= 1'b0;
      bus_write_en_q <= 1'b0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q          <= gnt_d;
            last_grant_q   <= gnt_d;
            wr_q           <= gnt_d ? m1_wr : m0_wr;
            bus_addr_q     <= gnt_d ? m1_addr : m0_addr;
            bus_wdata_q    <= gnt_d ? m1_wdata : m0_wdata;
            bus_write_en_q <= gnt_d ? m1_wr : m0_wr;
            bus_read_en_q  <= gnt_d ? ~m1_wr : ~m0_wr;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= 8'd0;
          if (!wr_q) state_q <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          wait_cnt_q <= wait_cnt_q + 8'd1;
          if (fin_err_d && (timeout_cnt_q != 16'hFFFF))
            timeout_cnt_q <= timeout_cnt_q + 16'd1;
        end
        S_DONE: begin
          m0_rdata_q <= 32'h0;
          m0_err_q   <= 1'b0;
          m1_rdata_q <= 32'h0;
          m1_err_q   <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Completion from ISSUE (write) or WAIT_RD (read) lands the response on the owner only.
      if (fin_d) begin
        m0_ack_q   <= ~gnt_q;
        m1_ack_q   <= gnt_q;
        m0_rdata_q <= gnt_q ? 32'h0 : fin_rdata_d;
        m1_rdata_q <= gnt_q ? fin_rdata_d : 32'h0;
        m0_err_q   <= ~gnt_q & fin_err_d;
        m1_err_q   <= gnt_q & fin_err_d;
        state_q    <= S_DONE;
      end
    end
  end

  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_read_en  = bus_read_en_q;
  assign bus_write_en = bus_write_en_q;
  assign m0_ack       = m0_ack_q;
  assign m0_rdata     = m0_rdata_q;
  assign m0_err       = m0_err_q;
  assign m1_ack       = m1_ack_q;
  assign m1_rdata     = m1_rdata_q;
  assign m1_err       = m1_err_q;
  assign timeout_cnt  = timeout_cnt_q;

endmodule

`default_nettype wire
